// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS pipeline slice.
//   alu_ctr_t   : ALU operation codes carried on AluCtrE.
//   fwd_sel_t   : operand forwarding selects (2'b11 is reserved and
//                 behaves like FWD_E).
//   mul_state_t : states of the iterative multiplier.
//   WIDTH       : default datapath width.
package mips_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_ctr_t;

   typedef enum logic [1:0] {
      FWD_E = 2'b00,
      FWD_W = 2'b01,
      FWD_M = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX inputs, forwarding sources and EX/MEM
// outputs of the execute stage.
//   master : the surrounding pipeline (drives ID/EX, forwarding, ResultW;
//            observes the EX/MEM outputs, WriteRegE and busyE).
//   slave  : the execute stage itself.
interface ex_stage_if #(
   parameter int WIDTH = mips_pkg::WIDTH
);
   logic             RegWriteE, MemtoRegE, MemWriteE, AluSrcE, RegDstE;
   logic             MulE;
   logic [1:0]       AluCtrE;
   logic [WIDTH-1:0] busaE, busbE, signE;
   logic [4:0]       rdE, rtE;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [WIDTH-1:0] ResultW;

   logic             RegWriteM, MemtoRegM, MemWriteM;
   logic [WIDTH-1:0] AluOutM, WriteDataM;
   logic [4:0]       WriteRegM;
   logic [4:0]       WriteRegE;
   logic             busyE;

   modport master (
      output RegWriteE, MemtoRegE, MemWriteE, AluSrcE, RegDstE, MulE, AluCtrE,
             busaE, busbE, signE, rdE, rtE, ForwardAE, ForwardBE, ResultW,
      input  RegWriteM, MemtoRegM, MemWriteM, AluOutM, WriteDataM, WriteRegM,
             WriteRegE, busyE
   );

   modport slave (
      input  RegWriteE, MemtoRegE, MemWriteE, AluSrcE, RegDstE, MulE, AluCtrE,
             busaE, busbE, signE, rdE, rtE, ForwardAE, ForwardBE, ResultW,
      output RegWriteM, MemtoRegM, MemWriteM, AluOutM, WriteDataM, WriteRegM,
             WriteRegE, busyE
   );
endinterface

// File: rtl/ex_stage_iter_mul.sv
// iter_mul: shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : sampled only in IDLE; latches a/b and begins iterating
//   a, b       : multiplicand / multiplier
//   busy       : high while iterating (BUSY)
//   done       : high for the single DONE cycle; product is valid then
//   product    : low WIDTH bits of a*b
module iter_mul
   import mips_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(MUL_CYCLES);

   mul_state_t       state;
   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [CW-1:0]    count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == CW'(MUL_CYCLES - 1))
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy    = (state == BUSY);
   assign done    = (state == DONE);
   assign product = acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ex_stage_if.slave -- ID/EX controls and operands,
//                forwarding selects, ResultW; EX/MEM register outputs,
//                WriteRegE (combinational) and busyE (stall request).
// ALU instructions complete in one cycle; a multiply runs in iter_mul and
// the EX/MEM register carries bubbles until its product is ready.
module ex_stage
   import mips_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
)(
   input  logic      clk,
   input  logic      rst_n,
   ex_stage_if.slave bus
);
   logic [WIDTH-1:0] srcA, fwdB, srcB, aluResult;
   logic             mulBusy, mulDone;
   logic [WIDTH-1:0] mulProduct;

   logic [WIDTH-1:0] aluOutReg, writeDataReg;
   logic [4:0]       writeRegReg;
   logic             regWriteReg, memtoRegReg, memWriteReg;
   logic             busyE;

   function automatic logic [WIDTH-1:0] fwdMux(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] idex,
                                                input logic [WIDTH-1:0] resW,
                                                input logic [WIDTH-1:0] aluM);
      case (fwd_sel_t'(sel))
         FWD_W:   return resW;
         FWD_M:   return aluM;
         default: return idex;   // FWD_E and the reserved encoding
      endcase
   endfunction

   always_comb begin
      srcA = fwdMux(bus.ForwardAE, bus.busaE, bus.ResultW, aluOutReg);
      fwdB = fwdMux(bus.ForwardBE, bus.busbE, bus.ResultW, aluOutReg);
      srcB = bus.AluSrcE ? bus.signE : fwdB;
      case (alu_ctr_t'(bus.AluCtrE))
         ADD:     aluResult = srcA + srcB;
         SUB:     aluResult = srcA - srcB;
         AND:     aluResult = srcA & srcB;
         default: aluResult = srcA | srcB;
      endcase
   end

   iter_mul #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (bus.MulE),
      .a       (srcA),
      .b       (srcB),
      .busy    (mulBusy),
      .done    (mulDone),
      .product (mulProduct)
   );

   // Idle is "neither busy nor done"; DONE deliberately drops the stall so
   // the still-held multiply in ID/EX is retired instead of restarted.
   assign busyE = (bus.MulE && !mulBusy && !mulDone) || mulBusy;

   // EX/MEM boundary register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluOutReg    <= '0;
         writeDataReg <= '0;
         writeRegReg  <= '0;
         regWriteReg  <= 1'b0;
         memtoRegReg  <= 1'b0;
         memWriteReg  <= 1'b0;
      end else if (mulDone) begin
         // Multiplies never store, so store data is left at zero.
         aluOutReg    <= mulProduct;
         writeDataReg <= '0;
         writeRegReg  <= bus.WriteRegE;
         regWriteReg  <= bus.RegWriteE;
         memtoRegReg  <= bus.MemtoRegE;
         memWriteReg  <= bus.MemWriteE;
      end else if (busyE) begin
         aluOutReg    <= '0;
         writeDataReg <= '0;
         writeRegReg  <= '0;
         regWriteReg  <= 1'b0;
         memtoRegReg  <= 1'b0;
         memWriteReg  <= 1'b0;
      end else begin
         aluOutReg    <= aluResult;
         writeDataReg <= fwdB;
         writeRegReg  <= bus.WriteRegE;
         regWriteReg  <= bus.RegWriteE;
         memtoRegReg  <= bus.MemtoRegE;
         memWriteReg  <= bus.MemWriteE;
      end
   end

   assign bus.WriteRegE  = bus.RegDstE ? bus.rdE : bus.rtE;
   assign bus.busyE      = busyE;
   assign bus.AluOutM    = aluOutReg;
   assign bus.WriteDataM = writeDataReg;
   assign bus.WriteRegM  = writeRegReg;
   assign bus.RegWriteM  = regWriteReg;
   assign bus.MemtoRegM  = memtoRegReg;
   assign bus.MemWriteM  = memWriteReg;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the decoded controls and operands held in the ID/EX register and forwards operands from the MEM and WB stages. It computes the ALU result, or a 32-cycle iterative multiply, and registers the result and pass-through controls into the EX/MEM boundary. It raises a stall to the hazard unit while a multiply is in flight.

## Interface
Parameters:
- `WIDTH`, 32: datapath width.
- `MUL_CYCLES`, 32: multiply iterations; must equal `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `AluSrcE`, `RegDstE`  in  1 each  decoded controls from ID/EX.
- `MulE`  in  1  instruction is a multiply (low word).
- `AluCtrE`  in  2  ALU operation code.
- `busaE`, `busbE`, `signE`  in  WIDTH each  register operands and sign-extended immediate.
- `rdE`, `rtE`  in  5 each  destination candidates.
- `ForwardAE`, `ForwardBE`  in  2 each  operand source: 00 = ID/EX, 01 = `ResultW`, 10 = `AluOutM`, 11 = reserved (treated as 00).
- `ResultW`  in  WIDTH  WB-stage write-back value.
- `RegWriteM`, `MemtoRegM`, `MemWriteM`  out  1 each  registered controls.
- `AluOutM`, `WriteDataM`  out  WIDTH each  registered result and store data.
- `WriteRegM`  out  5  registered destination register.
- `WriteRegE`  out  5  combinational destination, for the hazard unit.
- `busyE`  out  1  combinational stall request.

## Operation
- Operand A = forwarding mux on `busaE`.
- Forwarded B = forwarding mux on `busbE`; this is also the store data.
- Operand B = `signE` if `AluSrcE`, else forwarded B.
- `WriteRegE` = `rdE` if `RegDstE`, else `rtE`.
- ALU, with results wrapping modulo 2^WIDTH and no overflow trap:
  - `AluCtrE` 00 = A+B
  - 01 = A−B
  - 10 = A&B
  - 11 = A|B
- Multiply FSM with states IDLE, BUSY, DONE:
  - IDLE, `MulE`=0: ALU path. The EX/MEM register loads ALU result, forwarded B, `WriteRegE` and the controls.
  - IDLE, `MulE`=1: latch A into the multiplicand, B into the multiplier, clear the accumulator and the 5-bit counter; go to BUSY. EX/MEM loads a bubble.
  - BUSY: each cycle, if multiplier LSB is 1, accumulator += multiplicand. Then shift multiplicand left 1 and multiplier right 1, and increment the counter. After the iteration with counter = MUL_CYCLES−1, go to DONE. EX/MEM loads a bubble every BUSY cycle.
  - DONE: EX/MEM loads the accumulator into `AluOutM`, along with `WriteRegE` and the held controls. Go to IDLE.
- Bubble: `RegWriteM`=0, `MemWriteM`=0, `MemtoRegM`=0, `AluOutM`=0, `WriteDataM`=0, `WriteRegM`=0.
- `busyE` = (IDLE && `MulE`) || BUSY. It is 0 in DONE, so the held multiply does not restart.
- Hazard unit contract while `busyE`=1:
  - stalls F and D;
  - holds ID/EX and does not flush it.
- Later stages keep draining; operands are latched at start, so forwarded values changing later are harmless.
- `MulE` with `MemWriteE` or `MemtoRegE` set is illegal; behaviour is undefined.

## Timing
- ALU instruction: 1 cycle; result is visible on `AluOutM` the cycle after it is in E.
- Multiply entering E at cycle t:
  - `busyE` is high for cycles t … t+32 (33 cycles);
  - the FSM is in DONE at t+33;
  - `AluOutM` is valid at t+34.
- Back-to-back multiplies: the second starts from IDLE at t+34, with no lost cycle beyond its own latency.
- Reset: asynchronous on `rst_n` low.
  - FSM goes to IDLE; counter and accumulator are cleared.
  - All M outputs go to 0, including mid-multiply; the aborted multiply is discarded.
  - `busyE` after reset depends only on `MulE`.
- No other state survives reset.

## Structure
- Shared package `mips_pkg`:
  - `alu_ctr_t` enum (ADD, SUB, AND, OR);
  - `fwd_sel_t` enum (FWD_E, FWD_W, FWD_M);
  - `mul_state_t` enum (IDLE, BUSY, DONE);
  - constant `WIDTH`.
- One sub-module, `iter_mul`: the FSM, counter and shift-add datapath, with a start/busy/done/product interface.
- ALU, forwarding muxes and the EX/MEM register stay in `ex_stage`.

## Test plan
- Forwarding: `busaE`=5, `ForwardAE`=10 with `AluOutM`=100, `ForwardBE`=01 with `ResultW`=7, `AluCtrE`=00 → `AluOutM`=107 the next cycle.
- Immediate and sub: A=3, `AluSrcE`=1, `signE`=0xFFFFFFFF, `AluCtrE`=01 → `AluOutM`=4. A=0xFFFFFFFF plus B=1 → 0 (wrap).
- Multiply: A=0x0001_0003, B=0x0002_0005, `MulE`=1, `RegWriteE`=1, `rdE`=9, `RegDstE`=1:
  - `busyE` high exactly 33 cycles;
  - `RegWriteM`=0 during busy;
  - then `AluOutM`=0x000B_000F, `WriteRegM`=9, `RegWriteM`=1.
- Operand capture: start a multiply with `ForwardAE`=10, `AluOutM`=6, B=7; change `AluOutM` to 0 after one cycle → product 42.
- Reset mid-multiply: drop `rst_n` at BUSY count 10 → all M outputs 0 immediately, FSM in IDLE. After release, the held `MulE` restarts a full 33-cycle stall.
- Back-to-back: multiply then ADD with `ForwardAE`=10 → ADD sees the product in `AluOutM`, and its result follows one cycle later.
